mvu_pe_fold_ctrl: RTL and testbench

MVU_PE_FOLD_CTRL -- requirements
Module: mvu_pe_fold_ctrl

---
 rtl/mvau_defn_pkg.sv | 13 +
 rtl/mvu_fold_cnt.sv | 21 ++
 rtl/mvu_pe_fold_ctrl.sv | 59 +++++
 tb/tb_mvu_pe_fold_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mvau_defn_pkg.sv
// mvau_defn: shared MVAU definitions (fold defaults, stream types, fold FSM states).
package mvau_defn;
  localparam int SF_DEF = 4;
  localparam int NF_DEF = 2;
  localparam int TW = 8;
  typedef logic signed [TW-1:0] TW_t;
  typedef logic [7:0] TSrcI;
  typedef logic [15:0] TDstI;
  typedef enum logic [1:0] {IDLE, ACC, OUT} fold_state_e;
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/mvu_fold_cnt.sv
// mvu_fold_cnt: modulo-MAX fold counter; wrap_o flags the increment that returns to 0.
module mvu_fold_cnt
  import mvau_defn::*;
#(
  parameter int MAX = 4,
  parameter int W = clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = inc_i && (cnt_q == W'(MAX - 1));
  assign cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;
  assign cnt_o  = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_d;
endmodule

// File: rtl/mvu_pe_fold_ctrl.sv
// mvu_pe_fold_ctrl: sequences SIMD beats and accumulator folds of an MVAU PE,
// generating weight addresses and a handshaked result-valid per synapse fold.
module mvu_pe_fold_ctrl
  import mvau_defn::*;
#(
  parameter int SF = SF_DEF,
  parameter int NF = NF_DEF,
  parameter int AW = clog2_min1(SF * NF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_v,
  output logic          in_rdy,
  input  logic          out_rdy,
  output logic          do_mvau_stream,
  output logic          acc_clr,
  output logic [AW-1:0] wmem_addr,
  output logic          out_v,
  output logic          out_last
);
  localparam int SFW = clog2_min1(SF);
  localparam int NFW = clog2_min1(NF);
  fold_state_e state_q;
  logic out_v_q, out_last_q, beat, sf_wrap, nf_wrap;
  logic [SFW-1:0] sf_cnt;
  logic [NFW-1:0] nf_cnt;
  assign in_rdy         = (state_q != OUT) || out_rdy;
  assign beat           = in_v && in_rdy;
  assign do_mvau_stream = beat;
  assign acc_clr        = beat && (sf_cnt == '0);
  assign wmem_addr      = AW'(nf_cnt) * AW'(SF) + AW'(sf_cnt);
  assign out_v          = out_v_q;
  assign out_last       = out_last_q;
  mvu_fold_cnt #(.MAX(SF), .W(SFW)) u_sf (
    .clk(clk), .rst_n(rst_n), .inc_i(beat), .cnt_o(sf_cnt), .wrap_o(sf_wrap)
  );
  // nf_wrap fires only on the final beat of the final neuron fold, i.e. out_last
  mvu_fold_cnt #(.MAX(NF), .W(NFW)) u_nf (
    .clk(clk), .rst_n(rst_n), .inc_i(sf_wrap), .cnt_o(nf_cnt), .wrap_o(nf_wrap)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
    end else if (beat && sf_wrap) begin
      state_q    <= OUT;
      out_v_q    <= 1'b1;
      out_last_q <= nf_wrap;
    end else if (beat) begin
      state_q    <= ACC;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
    end else if (state_q == OUT && out_rdy) begin
      state_q    <= IDLE;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
    end
endmodule

// File: tb/tb_mvu_pe_fold_ctrl.sv
// tb_mvu_pe_fold_ctrl: directed and randomised checks of the fold controller
// for SF=4/NF=2 (instance a) and SF=1/NF=3 (instance b).
module tb_mvu_pe_fold_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic va, ra, dma, acla, ova, ola, irdya;
  logic vb, rb, dmb, aclb, ovb, olb, irdyb;
  logic [2:0] adda;
  logic [1:0] addb;
  int tests = 0, fails = 0;
  int acc, res, obs_beats, obs_res, a;
  bit pend, exp_last, exp_rdy, fire, cons;
  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  always #5 clk = ~clk;

  mvu_pe_fold_ctrl ua (
    .clk(clk), .rst_n(rst_n), .in_v(va), .in_rdy(irdya), .out_rdy(ra),
    .do_mvau_stream(dma), .acc_clr(acla), .wmem_addr(adda), .out_v(ova), .out_last(ola)
  );
  mvu_pe_fold_ctrl #(.SF(1), .NF(3)) ub (
    .clk(clk), .rst_n(rst_n), .in_v(vb), .in_rdy(irdyb), .out_rdy(rb),
    .do_mvau_stream(dmb), .acc_clr(aclb), .wmem_addr(addb), .out_v(ovb), .out_last(olb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    va = 1'b1; ra = 1'b1; vb = 1'b0; rb = 1'b1;
    #12;
    chk("rst_out_v", ova, 1'b0);
    chk("rst_out_last", ola, 1'b0);
    chk("rst_in_rdy", irdya, 1'b1);
    chk("rst_do_follows_in_v", dma, 1'b1);
    chk("rst_addr", adda, 0);
    chk("rst_out_v_b", ovb, 1'b0);
    va = 1'b0;
    #1 chk("rst_do_follows_in_v0", dma, 1'b0);
    tick;
    rst_n = 1'b1; va = 1'b1; ra = 1'b1;
    // continuous stream, 8 beats
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("s1_addr", adda, k);
      chk("s1_acc_clr", acla, (k % 4) == 0);
      chk("s1_do", dma, 1'b1);
      chk("s1_out_v", ova, k == 4);
      if (k == 4) chk("s1_out_last_first", ola, 1'b0);
      tick;
    end
    va = 1'b0;
    #1;
    chk("s1_out_v_second", ova, 1'b1);
    chk("s1_out_last_second", ola, 1'b1);
    chk("s1_in_rdy", irdya, 1'b1);
    chk("s1_addr_wrapped", adda, 0);
    tick;
    #1 chk("s1_idle", ova, 1'b0);
    // backpressure on the first result
    va = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("s2_addr", adda, k);
      tick;
    end
    ra = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s2_hold_out_v", ova, 1'b1);
      chk("s2_hold_out_last", ola, 1'b0);
      chk("s2_hold_in_rdy", irdya, 1'b0);
      chk("s2_hold_do", dma, 1'b0);
      chk("s2_hold_addr", adda, 4);
      tick;
    end
    ra = 1'b1;
    #1;
    chk("s2_release_do", dma, 1'b1);
    chk("s2_release_addr", adda, 4);
    chk("s2_release_acc_clr", acla, 1'b1);
    chk("s2_release_out_v", ova, 1'b1);
    tick;
    for (int k = 5; k < 8; k++) begin
      #1;
      chk("s2_addr2", adda, k);
      chk("s2_out_v_low", ova, 1'b0);
      tick;
    end
    va = 1'b0;
    #1;
    chk("s2_out_v_end", ova, 1'b1);
    chk("s2_out_last_end", ola, 1'b1);
    tick;
    #1 chk("s2_idle_addr", adda, 0);
    // in_v gaps
    a = 0;
    for (int i = 0; i < 7; i++) begin
      va = pat[i][0];
      #1;
      chk("s3_do", dma, pat[i][0]);
      chk("s3_addr", adda, a);
      chk("s3_out_v", ova, 1'b0);
      if (pat[i] != 0) a++;
      tick;
    end
    va = 1'b0;
    #1;
    chk("s3_out_v", ova, 1'b1);
    chk("s3_out_last", ola, 1'b0);
    chk("s3_addr_next_fold", adda, 4);
    tick;
    #1 chk("s3_out_v_drop", ova, 1'b0);
    // asynchronous reset mid-fold at addr 6
    va = 1'b1;
    for (int k = 4; k < 6; k++) begin
      #1 chk("s4_addr", adda, k);
      tick;
    end
    #1 chk("s4_addr6", adda, 6);
    rst_n = 1'b0;
    #1;
    chk("s4_async_addr", adda, 0);
    chk("s4_async_out_v", ova, 1'b0);
    chk("s4_rst_in_rdy", irdya, 1'b1);
    chk("s4_rst_do", dma, 1'b1);
    tick;
    rst_n = 1'b1;
    #1;
    chk("s4_first_addr", adda, 0);
    chk("s4_first_acc_clr", acla, 1'b1);
    tick;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("s4_addr_after", adda, k);
      chk("s4_acc_clr_after", acla, 1'b0);
      tick;
    end
    va = 1'b0; ra = 1'b0;
    #1 chk("s4_out_pending", ova, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s4_out_discard_v", ova, 1'b0);
    chk("s4_out_discard_last", ola, 1'b0);
    tick;
    rst_n = 1'b1; ra = 1'b1;
    // SF=1, NF=3 back-to-back results
    vb = 1'b1; rb = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("s5_addr", addb, c % 3);
      chk("s5_out_v", ovb, c >= 1);
      chk("s5_out_last", olb, (c >= 1) && ((c % 3) == 0));
      chk("s5_acc_clr", aclb, 1'b1);
      chk("s5_in_rdy", irdyb, 1'b1);
      tick;
    end
    vb = 1'b0;
    // random in_v/out_rdy against an independent model
    acc = 0; res = 0; obs_beats = 0; obs_res = 0; pend = 0; exp_last = 0;
    for (int n = 0; n < 10000; n++) begin
      va = ($urandom_range(0, 3) != 0);
      ra = $urandom_range(0, 1) != 0;
      #1;
      exp_rdy = !pend || ra;
      chk("rnd_addr", adda, acc % 8);
      chk("rnd_in_rdy", irdya, exp_rdy);
      chk("rnd_do", dma, va && exp_rdy);
      chk("rnd_out_v", ova, pend);
      if (pend) chk("rnd_out_last", ola, exp_last);
      obs_beats += int'(dma);
      obs_res += int'(ova && ra);
      fire = va && exp_rdy;
      cons = pend && ra;
      if (cons) res++;
      if (fire && (acc % 4) == 3) begin
        pend = 1'b1;
        exp_last = (acc % 8) == 7;
      end else if (cons) pend = 1'b0;
      if (fire) acc++;
      tick;
    end
    va = 1'b0; ra = 1'b1;
    #1;
    if (ova) obs_res++;
    if (pend) res++;
    tick;
    #1 chk("rnd_drained", ova, 1'b0);
    chk("rnd_beats", obs_beats, acc);
    chk("rnd_results", obs_res, res);
    chk("rnd_beats_per_result", obs_beats - (obs_beats % 4), 4 * obs_res);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
